// File: rtl/local_predictor_pkg.sv
// Shared types, constants and the saturating-counter step function for the
// local branch predictor.
package local_predictor_pkg;

    localparam int unsigned HIST_W_DEF   = 10;
    localparam int unsigned CTR_W_DEF    = 3;
    localparam int unsigned CTR_MAX_W    = 16;
    localparam int unsigned TAKEN_THRESH = 2 ** (CTR_W_DEF - 1);

    typedef logic [HIST_W_DEF-1:0] hist_t;
    typedef logic [CTR_W_DEF-1:0]  ctr_t;
    typedef logic [CTR_MAX_W-1:0]  ctr_wide_t;

    // Saturating step of a width-bit counter held in a wide container.
    function automatic ctr_wide_t sat_next(input ctr_wide_t   ctr,
                                           input logic        taken,
                                           input int unsigned width);
        ctr_wide_t max_v;
        ctr_wide_t res;
        max_v = ctr_wide_t'((32'd1 << width) - 32'd1);
        res   = ctr;
        if (taken) begin
            if (ctr != max_v) res = ctr + ctr_wide_t'(1);
        end else begin
            if (ctr != '0) res = ctr - ctr_wide_t'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/lp_sat_counter_table.sv
// Local prediction table: saturating counters with a registered read port
// and a single update port. Reads observe the pre-update contents.
module lp_sat_counter_table
    import local_predictor_pkg::*;
#(
    parameter int unsigned IDX_W    = 10,
    parameter int unsigned CTR_W    = 3,
    parameter int unsigned CTR_INIT = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rd_en_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [CTR_W-1:0] rd_ctr_o,
    input  logic             upd_en_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i
);

    localparam int unsigned DEPTH = 2 ** IDX_W;

    logic [CTR_W-1:0] tbl_q [DEPTH];
    logic [CTR_W-1:0] tbl_d [DEPTH];
    logic [CTR_W-1:0] rd_ctr_q;
    logic [CTR_W-1:0] rd_ctr_d;

    // Next-state: read latch holds when idle, updated entry saturates.
    always_comb begin
        tbl_d    = tbl_q;
        rd_ctr_d = rd_ctr_q;
        if (rd_en_i) begin
            rd_ctr_d = tbl_q[rd_idx_i];
        end
        if (upd_en_i) begin
            tbl_d[upd_idx_i] = CTR_W'(sat_next(CTR_MAX_W'(tbl_q[upd_idx_i]),
                                               upd_taken_i, CTR_W));
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= CTR_W'(CTR_INIT);
            end
            rd_ctr_q <= '0;
        end else begin
            tbl_q    <= tbl_d;
            rd_ctr_q <= rd_ctr_d;
        end
    end

    assign rd_ctr_o = rd_ctr_q;

endmodule

// File: rtl/local_predictor.sv
// Two-level local branch predictor: PC-indexed history table feeding a
// history-indexed table of saturating counters. Lookup latency is one cycle.
module local_predictor
    import local_predictor_pkg::*;
#(
    parameter int unsigned PC_IDX_W = 10,
    parameter int unsigned HIST_W   = 10,
    parameter int unsigned CTR_W    = 3,
    parameter int unsigned CTR_INIT = 0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                pred_valid_i,
    input  logic [PC_IDX_W-1:0] pred_pc_i,
    output logic                pred_valid_o,
    output logic                pred_taken_o,
    output logic [CTR_W-1:0]    pred_ctr_o,
    output logic [HIST_W-1:0]   pred_hist_o,
    input  logic                upd_valid_i,
    input  logic [PC_IDX_W-1:0] upd_pc_i,
    input  logic                upd_taken_i
);

    localparam int unsigned LHT_DEPTH = 2 ** PC_IDX_W;

    logic [HIST_W-1:0] lht_q [LHT_DEPTH];
    logic [HIST_W-1:0] lht_d [LHT_DEPTH];
    logic [HIST_W-1:0] pred_hist_q;
    logic [HIST_W-1:0] pred_hist_d;
    logic              pred_valid_q;
    logic              pred_valid_d;
    logic [HIST_W-1:0] rd_hist;
    logic [HIST_W-1:0] upd_hist;
    logic [CTR_W-1:0]  rd_ctr;

    assign rd_hist  = lht_q[pred_pc_i];
    assign upd_hist = lht_q[upd_pc_i];

    // History shifts left with the newest outcome in the LSB; the truncating
    // cast also covers a one-bit history.
    always_comb begin
        lht_d        = lht_q;
        pred_valid_d = pred_valid_i;
        pred_hist_d  = pred_hist_q;
        if (pred_valid_i) begin
            pred_hist_d = rd_hist;
        end
        if (upd_valid_i) begin
            lht_d[upd_pc_i] = HIST_W'({upd_hist, upd_taken_i});
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < LHT_DEPTH; i++) begin
                lht_q[i] <= '0;
            end
            pred_valid_q <= 1'b0;
            pred_hist_q  <= '0;
        end else begin
            lht_q        <= lht_d;
            pred_valid_q <= pred_valid_d;
            pred_hist_q  <= pred_hist_d;
        end
    end

    lp_sat_counter_table #(
        .IDX_W    (HIST_W),
        .CTR_W    (CTR_W),
        .CTR_INIT (CTR_INIT)
    ) u_lpt (
        .clock       (clock),
        .reset       (reset),
        .rd_en_i     (pred_valid_i),
        .rd_idx_i    (rd_hist),
        .rd_ctr_o    (rd_ctr),
        .upd_en_i    (upd_valid_i),
        .upd_idx_i   (upd_hist),
        .upd_taken_i (upd_taken_i)
    );

    assign pred_valid_o = pred_valid_q;
    assign pred_hist_o  = pred_hist_q;
    assign pred_ctr_o   = rd_ctr;
    assign pred_taken_o = rd_ctr[CTR_W-1];

    a_upd_taken_known: assert property (@(posedge clock) disable iff (reset)
        upd_valid_i |-> !$isunknown(upd_taken_i));

endmodule

// File: tb/tb_local_predictor.sv
// Bench for local_predictor: directed vector table plus scoreboarded model on
// the default configuration, a one-bit-history instance and a random sweep.
module tb_local_predictor;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // ---- default instance ----
    logic       p0_vi, p0_vo, p0_tk, u0_v, u0_t;
    logic [9:0] p0_pc, u0_pc, p0_hist;
    logic [2:0] p0_ctr;

    local_predictor u_dut0 (
        .clock(clock), .reset(reset),
        .pred_valid_i(p0_vi), .pred_pc_i(p0_pc),
        .pred_valid_o(p0_vo), .pred_taken_o(p0_tk),
        .pred_ctr_o(p0_ctr), .pred_hist_o(p0_hist),
        .upd_valid_i(u0_v), .upd_pc_i(u0_pc), .upd_taken_i(u0_t)
    );

    // ---- one-bit history instance ----
    logic       p1_vi, p1_vo, p1_tk, u1_v, u1_t;
    logic [1:0] p1_pc, u1_pc;
    logic [0:0] p1_hist;
    logic [2:0] p1_ctr;

    local_predictor #(.PC_IDX_W(2), .HIST_W(1), .CTR_W(3), .CTR_INIT(0)) u_dut1 (
        .clock(clock), .reset(reset),
        .pred_valid_i(p1_vi), .pred_pc_i(p1_pc),
        .pred_valid_o(p1_vo), .pred_taken_o(p1_tk),
        .pred_ctr_o(p1_ctr), .pred_hist_o(p1_hist),
        .upd_valid_i(u1_v), .upd_pc_i(u1_pc), .upd_taken_i(u1_t)
    );

    // ---- sweep instance ----
    logic       p2_vi, p2_vo, p2_tk, u2_v, u2_t;
    logic [1:0] p2_pc, u2_pc, p2_ctr;
    logic [3:0] p2_hist;

    local_predictor #(.PC_IDX_W(2), .HIST_W(4), .CTR_W(2), .CTR_INIT(1)) u_dut2 (
        .clock(clock), .reset(reset),
        .pred_valid_i(p2_vi), .pred_pc_i(p2_pc),
        .pred_valid_o(p2_vo), .pred_taken_o(p2_tk),
        .pred_ctr_o(p2_ctr), .pred_hist_o(p2_hist),
        .upd_valid_i(u2_v), .upd_pc_i(u2_pc), .upd_taken_i(u2_t)
    );

    typedef struct {
        int hist;
        int ctr;
        int tk;
    } pred_t;

    typedef struct {
        bit pv; int ppc; bit uv; int upc; bit ut; bit alt; int rep;
        bit chk; int e_hist; int e_ctr; int e_tk;
    } vec_t;

    int    m0_lht [1024];
    int    m0_lpt [1024];
    int    m2_lht [4];
    int    m2_lpt [16];
    pred_t q0 [$];
    pred_t q2 [$];
    pred_t last0;
    pred_t last2;
    vec_t  tbl [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int satf(input int c, input bit t, input int maxv);
        if (t) return (c < maxv) ? c + 1 : maxv;
        return (c > 0) ? c - 1 : 0;
    endfunction

    task automatic model0_reset();
        for (int i = 0; i < 1024; i++) begin
            m0_lht[i] = 0;
            m0_lpt[i] = 0;
        end
        q0.delete();
        last0 = '{0, 0, 0};
    endtask

    // One cycle on the default instance, scoreboarded against the model.
    task automatic step0(input bit pv, input int ppc, input bit uv, input int upc, input bit ut);
        pred_t e;
        int    h;
        p0_vi = pv; p0_pc = 10'(ppc);
        u0_v  = uv; u0_pc = 10'(upc); u0_t = ut;
        if (pv) begin
            e.hist = m0_lht[ppc];
            e.ctr  = m0_lpt[e.hist];
            e.tk   = (e.ctr >= 4) ? 1 : 0;
            q0.push_back(e);
        end
        if (uv) begin
            h = m0_lht[upc];
            m0_lpt[h]   = satf(m0_lpt[h], ut, 7);
            m0_lht[upc] = ((h << 1) | int'(ut)) & 'h3FF;
        end
        @(posedge clock);
        #1;
        p0_vi = 1'b0; u0_v = 1'b0;
        chk("sb0_valid", 32'(p0_vo), 32'(pv));
        if (pv) begin
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL sb0_queue actual=empty required=entry");
            end else begin
                last0 = q0.pop_front();
            end
        end
        chk("sb0_hist", 32'(p0_hist), 32'(last0.hist));
        chk("sb0_ctr", 32'(p0_ctr), 32'(last0.ctr));
        chk("sb0_taken", 32'(p0_tk), 32'(last0.tk));
    endtask

    task automatic step1(input bit pv, input int ppc, input bit uv, input int upc, input bit ut);
        p1_vi = pv; p1_pc = 2'(ppc);
        u1_v  = uv; u1_pc = 2'(upc); u1_t = ut;
        @(posedge clock);
        #1;
        p1_vi = 1'b0; u1_v = 1'b0;
    endtask

    task automatic look1(input string name, input int pc, input int eh, input int ec, input int et);
        step1(1'b1, pc, 1'b0, 0, 1'b0);
        chk({name, "_valid"}, 32'(p1_vo), 32'd1);
        chk({name, "_hist"}, 32'(p1_hist), 32'(eh));
        chk({name, "_ctr"}, 32'(p1_ctr), 32'(ec));
        chk({name, "_taken"}, 32'(p1_tk), 32'(et));
    endtask

    task automatic step2(input bit pv, input int ppc, input bit uv, input int upc, input bit ut);
        pred_t e;
        int    h;
        p2_vi = pv; p2_pc = 2'(ppc);
        u2_v  = uv; u2_pc = 2'(upc); u2_t = ut;
        if (pv) begin
            e.hist = m2_lht[ppc];
            e.ctr  = m2_lpt[e.hist];
            e.tk   = (e.ctr >= 2) ? 1 : 0;
            q2.push_back(e);
        end
        if (uv) begin
            h = m2_lht[upc];
            m2_lpt[h]   = satf(m2_lpt[h], ut, 3);
            m2_lht[upc] = ((h << 1) | int'(ut)) & 'hF;
        end
        @(posedge clock);
        #1;
        p2_vi = 1'b0; u2_v = 1'b0;
        chk("sb2_valid", 32'(p2_vo), 32'(pv));
        if (pv) begin
            if (q2.size() == 0) begin
                errors++;
                $display("FAIL sb2_queue actual=empty required=entry");
            end else begin
                last2 = q2.pop_front();
            end
        end
        chk("sb2_hist", 32'(p2_hist), 32'(last2.hist));
        chk("sb2_ctr", 32'(p2_ctr), 32'(last2.ctr));
        chk("sb2_taken", 32'(p2_tk), 32'(last2.tk));
    endtask

    initial begin
        // pv ppc uv upc ut alt rep chk hist ctr tk
        tbl[0]  = '{1, 0,    0, 0, 0, 0, 1,  1, 0,     0, 0};
        tbl[1]  = '{1, 5,    0, 0, 0, 0, 1,  1, 0,     0, 0};
        tbl[2]  = '{1, 1023, 0, 0, 0, 0, 1,  1, 0,     0, 0};
        tbl[3]  = '{0, 0,    1, 5, 1, 0, 10, 0, 0,     0, 0};
        tbl[4]  = '{1, 5,    0, 0, 0, 0, 1,  1, 'h3FF, 0, 0};
        tbl[5]  = '{0, 0,    1, 5, 1, 0, 4,  0, 0,     0, 0};
        tbl[6]  = '{1, 5,    0, 0, 0, 0, 1,  1, 'h3FF, 4, 1};
        tbl[7]  = '{0, 0,    0, 0, 0, 0, 1,  1, 'h3FF, 4, 1};
        tbl[8]  = '{1, 5,    1, 5, 1, 0, 1,  1, 'h3FF, 4, 1};
        tbl[9]  = '{1, 5,    0, 0, 0, 0, 1,  1, 'h3FF, 5, 1};
        tbl[10] = '{0, 0,    1, 5, 1, 0, 10, 0, 0,     0, 0};
        tbl[11] = '{1, 5,    0, 0, 0, 0, 1,  1, 'h3FF, 7, 1};
        tbl[12] = '{0, 0,    1, 5, 1, 0, 1,  0, 0,     0, 0};
        tbl[13] = '{1, 5,    0, 0, 0, 0, 1,  1, 'h3FF, 7, 1};
        tbl[14] = '{0, 0,    1, 2, 1, 1, 20, 0, 0,     0, 0};
        tbl[15] = '{1, 2,    0, 0, 0, 0, 1,  1, 'h2AA, 5, 1};
        tbl[16] = '{0, 0,    1, 2, 1, 0, 1,  0, 0,     0, 0};
        tbl[17] = '{1, 2,    0, 0, 0, 0, 1,  1, 'h155, 0, 0};

        p0_vi = 0; p0_pc = '0; u0_v = 0; u0_pc = '0; u0_t = 0;
        p1_vi = 0; p1_pc = '0; u1_v = 0; u1_pc = '0; u1_t = 0;
        p2_vi = 0; p2_pc = '0; u2_v = 0; u2_pc = '0; u2_t = 0;

        reset = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        chk("rst_p0_valid", 32'(p0_vo), 32'd0);
        chk("rst_p0_hist", 32'(p0_hist), 32'd0);
        chk("rst_p0_ctr", 32'(p0_ctr), 32'd0);
        chk("rst_p2_ctr", 32'(p2_ctr), 32'd0);
        chk("rst_p2_valid", 32'(p2_vo), 32'd0);
        reset = 1'b0;
        model0_reset();

        for (int i = 0; i < 18; i++) begin
            for (int r = 0; r < tbl[i].rep; r++) begin
                step0(tbl[i].pv, tbl[i].ppc, tbl[i].uv, tbl[i].upc,
                      tbl[i].alt ? (tbl[i].ut ^ bit'(r % 2)) : tbl[i].ut);
            end
            if (tbl[i].chk) begin
                chk($sformatf("row%0d_valid", i), 32'(p0_vo), 32'(tbl[i].pv));
                chk($sformatf("row%0d_hist", i), 32'(p0_hist), 32'(tbl[i].e_hist));
                chk($sformatf("row%0d_ctr", i), 32'(p0_ctr), 32'(tbl[i].e_ctr));
                chk($sformatf("row%0d_taken", i), 32'(p0_tk), 32'(tbl[i].e_tk));
            end
        end

        // Mid-run asynchronous reset clears outputs before the next edge.
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(p0_vo), 32'd0);
        chk("mid_rst_hist", 32'(p0_hist), 32'd0);
        chk("mid_rst_ctr", 32'(p0_ctr), 32'd0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        model0_reset();
        step0(1'b1, 5, 1'b0, 0, 1'b0);
        chk("post_rst_pc5_hist", 32'(p0_hist), 32'd0);
        chk("post_rst_pc5_ctr", 32'(p0_ctr), 32'd0);
        step0(1'b1, 2, 1'b0, 0, 1'b0);
        chk("post_rst_pc2_hist", 32'(p0_hist), 32'd0);
        chk("post_rst_pc2_taken", 32'(p0_tk), 32'd0);
        step0(1'b1, 0, 1'b0, 0, 1'b0);
        chk("post_rst_pc0_ctr", 32'(p0_ctr), 32'd0);

        // One-bit history: counter at history 0 bottoms out without wrapping.
        for (int i = 0; i < 10; i++) step1(1'b0, 0, 1'b1, 3, 1'b0);
        look1("h1_n10", 3, 0, 0, 0);
        for (int i = 0; i < 10; i++) step1(1'b0, 0, 1'b1, 3, 1'b0);
        look1("h1_n20", 3, 0, 0, 0);
        step1(1'b0, 0, 1'b1, 3, 1'b1);
        look1("h1_t_pc0", 0, 0, 1, 0);
        look1("h1_t_pc3", 3, 1, 0, 0);

        // Random sweep on the small configuration.
        for (int i = 0; i < 4; i++) m2_lht[i] = 0;
        for (int i = 0; i < 16; i++) m2_lpt[i] = 1;
        last2 = '{0, 0, 0};
        for (int i = 0; i < 5000; i++) begin
            step2(bit'($urandom_range(0, 1)), $urandom_range(0, 3),
                  bit'($urandom_range(0, 1)), $urandom_range(0, 3),
                  bit'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
